fpu_apu_issue: RTL

//  Initiator side of the APU request/response protocol served by the FPU wrapper.

---
 rtl/fpu_apu_pkg.sv | 23 ++
 rtl/fpu_apu_tag_fifo.sv | 61 ++++++
 rtl/fpu_apu_issue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fpu_apu_pkg.sv
// Shared types and constants for the APU initiator between FP decode and the FPU wrapper.
package fpu_apu_pkg;

  localparam int unsigned APU_FLAGS_W = 11;
  localparam logic [1:0]  FMT_FP32    = 2'b10;
  localparam logic [2:0]  RM_DYN      = 3'b111;

  typedef logic [2:0] rm_t;
  typedef logic [4:0] fflags_t;

  typedef struct packed {
    logic [5:0]             op;
    logic [2:0][31:0]       operands;
    logic [APU_FLAGS_W-1:0] flags;
  } apu_req_t;

  typedef enum logic {StIdle, StReq} state_e;

  function automatic rm_t rm_eff(rm_t rm, rm_t frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

endpackage

// File: rtl/fpu_apu_tag_fifo.sv
// Synchronous tag FIFO holding destination registers of granted, unanswered APU requests.
module fpu_apu_tag_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so push is allowed on a full FIFO when popping.
  assign pop  = pop_i && !empty_o;
  assign push = push_i && (!full_o || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fpu_apu_issue.sv
// APU request initiator: issues FP ops to the FPU, tracks tags in order, writes results back.
// Optional performance counters are built when APU_PERF_CNT_EN is defined.
module fpu_apu_issue
  import fpu_apu_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned TAG_W     = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [5:0]             instr_op_i,
  input  logic [2:0]             instr_rm_i,
  input  logic [TAG_W-1:0]       instr_rd_i,
  input  logic [2:0][31:0]       instr_ops_i,
  input  logic [2:0]             frm_i,
  output logic                   apu_req_o,
  input  logic                   apu_gnt_i,
  output logic [2:0][31:0]       apu_operands_o,
  output logic [5:0]             apu_op_o,
  output logic [APU_FLAGS_W-1:0] apu_flags_o,
  input  logic                   apu_rvalid_i,
  input  logic [31:0]            apu_rdata_i,
  input  logic [4:0]             apu_rflags_i,
  output logic                   wb_valid_o,
  output logic [TAG_W-1:0]       wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [31:0]            perf_issued_o,
  output logic [31:0]            perf_stall_o
);

  state_e           state_q, state_d;
  apu_req_t         req_q, req_d;
  logic [TAG_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_valid_q, wb_valid_d, err_q, err_d;
  fflags_t          fflags_q, fflags_d;
  logic             fifo_empty, fifo_full, accept, grant, bypass, push, pop;
  logic [TAG_W-1:0] head;

  assign accept = (state_q == StIdle) && instr_valid_i && !fifo_full;
  assign grant  = (state_q == StReq) && apu_gnt_i;
  // Zero-latency FPU: response belongs to the request granted this very cycle.
  assign bypass = apu_rvalid_i && fifo_empty && grant;
  assign push   = grant && !bypass;
  assign pop    = apu_rvalid_i && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rd_d       = rd_q;
    wb_valid_d = pop || bypass;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q || (apu_rvalid_i && fifo_empty && !grant);
    fflags_d   = fflags_clr_i ? '0 : fflags_q;
    if (apu_rvalid_i) fflags_d = fflags_d | apu_rflags_i;
    if (wb_valid_d) begin
      wb_rd_d   = bypass ? rd_q : head;
      wb_data_d = apu_rdata_i;
    end
    case (state_q)
      StIdle: begin
        if (accept) begin
          req_d.op       = instr_op_i;
          req_d.operands = instr_ops_i;
          req_d.flags    = {FMT_FP32, 3'b000, 3'b000, rm_eff(instr_rm_i, frm_i)};
          rd_d           = instr_rd_i;
          state_d        = StReq;
        end
      end
      StReq: begin
        if (apu_gnt_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      req_q      <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      fflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      fflags_q   <= fflags_d;
    end
  end

  fpu_apu_tag_fifo #(
    .Depth (MAX_OUTST),
    .Width (TAG_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (rd_q),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_ready_o  = (state_q == StIdle) && !fifo_full;
  assign apu_req_o      = (state_q == StReq);
  assign apu_op_o       = req_q.op;
  assign apu_operands_o = req_q.operands;
  assign apu_flags_o    = req_q.flags;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign fflags_o       = fflags_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q == StReq) || !fifo_empty;

`ifdef APU_PERF_CNT_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q + (grant ? 32'd1 : 32'd0);
    stall_d  = stall_q + ((apu_req_o && !apu_gnt_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_issued_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule
